// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states, default depth.
package mau_pkg;

    localparam int unsigned DEPTH_WORDS = 64;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response handshake of the memory access unit.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lane_align.sv
// Little-endian lane handling: sub-word store merge and load extract with sign/zero extension.
module lane_align (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    output logic [31:0] new_word,
    output logic [31:0] rdata
);
    import mau_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        new_word = old_word;
        rdata    = old_word;
        byte_v   = old_word[{offset, 3'b000} +: 8];
        half_v   = old_word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                new_word[{offset, 3'b000} +: 8] = wdata[7:0];
                rdata = {{24{sign_ext & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                new_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
                rdata = {{16{sign_ext & half_v[15]}}, half_v};
            end
            default: begin
                new_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for the word-addressed data memory (RMW for sub-word stores).
// Define MAU_MISALIGN_TRAP_EN to trap misaligned half/word accesses with resp_err.
module mem_access_unit #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = mau_pkg::DEPTH_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [31:0]       mem_read_data
);
    import mau_pkg::*;

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    mau_state_t        state_q;
    logic              write_q;
    logic              sign_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rdata_q;

    logic [1:0]        size_n;
    logic [1:0]        off_n;
    logic [31:0]       merged_word;
    logic [31:0]       load_data;
    logic              unused_addr;

    // Upper address bits wrap away; the index only needs bits [IDX_W+1:2].
    assign unused_addr = ^bus.req_addr[ADDR_W-1:IDX_W+2];

    always_comb begin
        size_n = (bus.req_size == 2'd3) ? SZ_WORD : bus.req_size;
        case (size_n)
            SZ_BYTE: off_n = bus.req_addr[1:0];
            SZ_HALF: off_n = {bus.req_addr[1], 1'b0};
            default: off_n = 2'b00;
        endcase
    end

`ifdef MAU_MISALIGN_TRAP_EN
    logic misaligned;
    logic err_q;

    assign misaligned = (size_n == SZ_HALF && bus.req_addr[0]) ||
                        (size_n == SZ_WORD && bus.req_addr[1:0] != 2'b00);
    assign bus.resp_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && bus.req_valid) begin
            err_q <= misaligned;
        end
    end
`else
    assign bus.resp_err = 1'b0;
`endif

    lane_align u_lane_align (
        .old_word (mem_read_data),
        .wdata    (wdata_q),
        .size     (size_q),
        .offset   (off_q),
        .sign_ext (sign_q),
        .new_word (merged_word),
        .rdata    (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            sign_q      <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        write_q    <= bus.req_write;
                        sign_q     <= bus.req_signed;
                        size_q     <= size_n;
                        off_q      <= off_n;
                        wdata_q    <= bus.req_wdata;
                        mem_addr_q <= ADDR_W'(bus.req_addr[IDX_W+1:2]);
                        rdata_q    <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state_q <= StResp;
                        end else
`endif
                        if (bus.req_write && size_n == SZ_WORD) begin
                            mem_wdata_q <= bus.req_wdata;
                            state_q     <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (write_q) begin
                        mem_wdata_q <= merged_word;
                        state_q     <= StWrite;
                    end else begin
                        rdata_q <= load_data;
                        state_q <= StResp;
                    end
                end
                StWrite: begin
                    state_q <= StResp;
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_q == StIdle) && !rst;
    assign bus.resp_valid  = (state_q == StResp);
    assign bus.resp_rdata  = rdata_q;
    assign mem_addr        = mem_addr_q;
    assign mem_write_data  = mem_wdata_q;
    assign mem_MemRead     = (state_q == StRead);
    assign mem_MemWrite    = (state_q == StWrite);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        load_mem;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_read_data;
    logic [31:0] mem [64];
    logic [7:0]  ref_b [256];
    int          checks;
    int          errors;
    wire         unused_tb = ^mem_addr[31:6];

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .ADDR_W      (32),
        .DEPTH_WORDS (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_MemWrite   (mem_MemWrite),
        .mem_MemRead    (mem_MemRead),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        return (w == 5) ? 32'd7 : 32'(w);
    endfunction

    assign mem_read_data = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_MemWrite) begin
            mem[mem_addr[5:0]] <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    // One request through the unit, compared with what the byte-array model predicts.
    task automatic do_op(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input int bp);
        int          nb, base, lat, rds, wrs, both;
        int          exp_lat, exp_rds, exp_wrs;
        logic [31:0] exp_rd, held;
        logic        exp_err, mis;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(addr[7:0]);
        mis  = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
        mis = (base % nb) != 0;
`endif
        base = base - (base % nb);
        exp_rd = 32'd0; exp_err = 1'b0;
        if (mis) begin
            exp_err = 1'b1; exp_lat = 1; exp_rds = 0; exp_wrs = 0;
        end else if (wr) begin
            exp_lat = (nb == 4) ? 2 : 3; exp_rds = (nb == 4) ? 0 : 1; exp_wrs = 1;
            for (int i = 0; i < nb; i++) ref_b[base + i] = wd[8*i +: 8];
        end else begin
            exp_lat = 2; exp_rds = 1; exp_wrs = 0;
            for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(ref_b[base + i]) << (8 * i));
            if (sg && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * nb));
        end

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
        bus.resp_ready = (bp == 0);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1; rds = 0; wrs = 0; both = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.resp_valid) break;
            rds += int'(mem_MemRead);
            wrs += int'(mem_MemWrite);
            both += int'(mem_MemRead & mem_MemWrite);
            @(posedge clk);
            lat++;
        end
        check("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("memread_cycles", 32'(rds), 32'(exp_rds));
        check("memwrite_cycles", 32'(wrs), 32'(exp_wrs));
        check("strobes_exclusive", 32'(both), 32'd0);
        check("resp_rdata", bus.resp_rdata, exp_rd);
        check("resp_err", 32'(bus.resp_err), 32'(exp_err));
        held = bus.resp_rdata;
        for (int k = 0; k < bp; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("bp_rdata_stable", bus.resp_rdata, held);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        if (wr) check("mem_word", mem[base / 4], ref_word(base / 4));
    endtask

    initial begin
        int wrs, vld;
        checks = 0; errors = 0;
        rst = 1'b1; load_mem = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
        for (int w = 0; w < 64; w++)
            for (int b = 0; b < 4; b++) ref_b[4*w+b] = init_word(w)[8*b +: 8];
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_memread", 32'(mem_MemRead), 32'd0);
        check("rst_memwrite", 32'(mem_MemWrite), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        rst = 1'b0; load_mem = 1'b0;

        do_op(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
        check("lw_0x14_value", bus.resp_rdata, 32'h0000_0007);
        do_op(1'b1, 2'd0, 1'b0, 32'h0D, 32'hAB, 0);
        check("sb_mem3", mem[3], 32'h0000_AB03);
        do_op(1'b0, 2'd0, 1'b1, 32'h0D, 32'h0, 0);
        check("lb_signed", bus.resp_rdata, 32'hFFFF_FFAB);
        do_op(1'b0, 2'd0, 1'b0, 32'h0D, 32'h0, 0);
        check("lbu", bus.resp_rdata, 32'h0000_00AB);
        do_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h8001, 0);
        check("sh_mem8", mem[8], 32'h8001_0008);
        do_op(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 3);
        check("lh_signed", bus.resp_rdata, 32'hFFFF_8001);
        do_op(1'b0, 2'd2, 1'b0, 32'h15, 32'h0, 0);
`ifdef MAU_MISALIGN_TRAP_EN
        check("misaligned_rdata", bus.resp_rdata, 32'h0);
`else
        check("misaligned_rdata", bus.resp_rdata, 32'h0000_0007);
`endif

        // Reset pulse during the READ cycle of a byte store.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0D; bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0; rst = 1'b1;
        #1;
        check("midrst_memread", 32'(mem_MemRead), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        wrs = int'(mem_MemWrite); vld = int'(bus.resp_valid);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            wrs += int'(mem_MemWrite);
            vld += int'(bus.resp_valid);
        end
        check("midrst_no_write", 32'(wrs), 32'd0);
        check("midrst_no_resp", 32'(vld), 32'd0);
        check("midrst_ready_after", 32'(bus.req_ready), 32'd1);
        check("midrst_mem3", mem[3], ref_word(3));

        for (int n = 0; n < 40; n++) begin
            do_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                  ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        for (int w = 0; w < 64; w++) check("final_mem", mem[w], ref_word(w));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
